// File: rtl/mem_arb_pkg.sv
// ============================================================================
//  mem_arb_pkg
//  Shared types and constants for the unified memory arbiter.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IF_BUSY = 2'd1,
      D_BUSY  = 2'd2
   } state_t;

   localparam logic GNT_FETCH = 1'b0;
   localparam logic GNT_DATA  = 1'b1;

   localparam int WD_W = 10;

endpackage

`default_nettype wire

// File: rtl/mem_arb_watchdog.sv
// ============================================================================
//  mem_arb_watchdog
//  Busy-cycle counter that flags a hung memory transaction.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module mem_arb_watchdog
   import mem_arb_pkg::*;
#(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_timeout
);

   localparam logic [WD_W-1:0] c_last = WD_W'(TIMEOUT_CYC - 1);

   logic [WD_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Fires on the busy cycle whose increment makes the count reach TIMEOUT_CYC.
   assign o_timeout = i_en && (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
// ============================================================================
//  unified_mem_arbiter
//  Fetch/data arbiter for a single-port unified memory with a hang watchdog.
//  Optional: define MEM_ARB_FAIR_EN for round-robin conflict resolution.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module unified_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [DATA_W-1:0] if_rdata_o,
   output logic              if_ack_o,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   output logic [DATA_W-1:0] d_rdata_o,
   output logic              d_ack_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              mem_ack_i,
   output logic              busy_o,
   output logic              err_o
);

   state_t r_state;
   state_t w_state_nxt;

   logic              r_if_ack;
   logic              r_d_ack;
   logic [DATA_W-1:0] r_if_rdata;
   logic [DATA_W-1:0] r_d_rdata;
   logic              r_mem_req;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic              r_err;

   logic w_if_elig;
   logic w_d_elig;
   logic w_any_ack;
   logic w_grant;
   logic w_winner;
   logic w_conflict_pick;
   logic w_busy;
   logic w_done;
   logic w_abort;
   logic w_timeout;
   logic w_wd_en;

   assign w_any_ack = r_if_ack | r_d_ack;
   assign w_if_elig = if_req_i & ~r_if_ack;
   assign w_d_elig  = d_req_i & ~r_d_ack;
   assign w_busy    = (r_state != IDLE);
   assign w_wd_en   = w_busy & ~mem_ack_i;
   assign w_done    = w_busy & mem_ack_i;
   assign w_abort   = w_timeout & ~mem_ack_i;

`ifdef MEM_ARB_FAIR_EN
   logic r_last_served;

   assign w_conflict_pick = ~r_last_served;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_last_served <= GNT_FETCH;
      end else if (w_grant) begin
         r_last_served <= w_winner;
      end
   end
`else
   assign w_conflict_pick = GNT_DATA;
`endif

   // No grant while an ack is out, so a requester still holding its request
   // through the ack cycle is compared fairly against the other next cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      w_winner    = GNT_DATA;
      case (r_state)
         IDLE: begin
            if (!w_any_ack && (w_if_elig || w_d_elig)) begin
               w_grant = 1'b1;
               if (w_if_elig && w_d_elig) begin
                  w_winner = w_conflict_pick;
               end else begin
                  w_winner = w_d_elig ? GNT_DATA : GNT_FETCH;
               end
               w_state_nxt = (w_winner == GNT_DATA) ? D_BUSY : IF_BUSY;
            end
         end
         IF_BUSY, D_BUSY: begin
            if (mem_ack_i || w_timeout) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_if_ack    <= 1'b0;
         r_d_ack     <= 1'b0;
         r_if_rdata  <= '0;
         r_d_rdata   <= '0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_err       <= 1'b0;
      end else begin
         r_if_ack <= 1'b0;
         r_d_ack  <= 1'b0;
         if (w_grant) begin
            r_mem_req <= 1'b1;
            if (w_winner == GNT_DATA) begin
               r_mem_we    <= d_we_i;
               r_mem_addr  <= d_addr_i;
               r_mem_wdata <= d_wdata_i;
            end else begin
               r_mem_we    <= 1'b0;
               r_mem_addr  <= if_addr_i;
               r_mem_wdata <= '0;
            end
         end else if (w_done || w_abort) begin
            r_mem_req <= 1'b0;
            if (r_state == IF_BUSY) begin
               r_if_ack   <= 1'b1;
               r_if_rdata <= w_done ? mem_rdata_i : '0;
            end else begin
               r_d_ack   <= 1'b1;
               r_d_rdata <= (w_done && !r_mem_we) ? mem_rdata_i : '0;
            end
            if (w_abort) begin
               r_err <= 1'b1;
            end
         end
      end
   end

   mem_arb_watchdog #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_watchdog (
      .clk       (clk_i),
      .rst       (rst_i),
      .i_clr     (w_grant),
      .i_en      (w_wd_en),
      .o_timeout (w_timeout)
   );

   assign if_ack_o    = r_if_ack;
   assign d_ack_o     = r_d_ack;
   assign if_rdata_o  = r_if_rdata;
   assign d_rdata_o   = r_d_rdata;
   assign mem_req_o   = r_mem_req;
   assign mem_we_o    = r_mem_we;
   assign mem_addr_o  = r_mem_addr;
   assign mem_wdata_o = r_mem_wdata;
   assign busy_o      = w_busy;
   assign err_o       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
// ============================================================================
//  tb_unified_mem_arbiter
//  Scoreboard bench for unified_mem_arbiter (TIMEOUT_CYC = 4).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_unified_mem_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic [31:0] if_rdata_o;
   logic        if_ack_o;
   logic        d_req_i;
   logic        d_we_i;
   logic [31:0] d_addr_i;
   logic [31:0] d_wdata_i;
   logic [31:0] d_rdata_o;
   logic        d_ack_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] mem_rdata_i;
   logic        mem_ack_i;
   logic        busy_o;
   logic        err_o;

   typedef struct packed {
      logic        port;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_err  = 0;
   int   n_acks = 0;
   int   mem_lat = 1;

   unified_mem_arbiter #(
      .ADDR_W      (32),
      .DATA_W      (32),
      .TIMEOUT_CYC (4)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .if_req_i    (if_req_i),
      .if_addr_i   (if_addr_i),
      .if_rdata_o  (if_rdata_o),
      .if_ack_o    (if_ack_o),
      .d_req_i     (d_req_i),
      .d_we_i      (d_we_i),
      .d_addr_i    (d_addr_i),
      .d_wdata_i   (d_wdata_i),
      .d_rdata_o   (d_rdata_o),
      .d_ack_o     (d_ack_o),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_rdata_i (mem_rdata_i),
      .mem_ack_i   (mem_ack_i),
      .busy_o      (busy_o),
      .err_o       (err_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return (a == 32'h40) ? 32'h00A00093 : (a * 3 + 32'h1000);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Memory model: acks mem_lat cycles into a request; mem_lat = 0 never acks.
   initial begin
      int  cnt;
      bit  sent;
      cnt = 0;
      sent = 1'b0;
      mem_ack_i = 1'b0;
      mem_rdata_i = '0;
      forever begin
         @(negedge clk_i);
         mem_ack_i = 1'b0;
         if (mem_req_o && !sent) begin
            cnt++;
            if (mem_lat != 0 && cnt == mem_lat) begin
               mem_ack_i = 1'b1;
               mem_rdata_i = mem_f(mem_addr_o);
               sent = 1'b1;
            end
         end else if (!mem_req_o) begin
            cnt = 0;
            sent = 1'b0;
         end
      end
   end

   // Monitor: every ack pops one expectation.
   always @(negedge clk_i) begin
      exp_t e;
      if (if_ack_o === 1'b1 || d_ack_o === 1'b1) begin
         n_acks++;
         check("ack_exclusive", {31'd0, if_ack_o & d_ack_o}, 32'd0);
         if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_ack: got if_ack=%b d_ack=%b expected none", if_ack_o, d_ack_o);
         end else begin
            e = sb.pop_front();
            check("ack_port", {31'd0, d_ack_o}, {31'd0, e.port});
            check("ack_rdata", d_ack_o ? d_rdata_o : if_rdata_o, e.data);
         end
      end
   end

   task automatic txn(input bit port, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input int lat,
                      input logic [31:0] exp_rd, input int exp_busy);
      int cyc;
      int guard;
      mem_lat = lat;
      sb.push_back({port, exp_rd});
      @(negedge clk_i);
      if (port) begin
         d_req_i = 1'b1; d_we_i = we; d_addr_i = addr; d_wdata_i = wdata;
      end else begin
         if_req_i = 1'b1; if_addr_i = addr;
      end
      @(negedge clk_i);
      check("grant_latency", {31'd0, mem_req_o}, 32'd1);
      check("mem_we", {31'd0, mem_we_o}, {31'd0, port & we});
      check("mem_addr", mem_addr_o, addr);
      if (port && we) check("mem_wdata", mem_wdata_o, wdata);
      cyc = 0;
      guard = 0;
      while (!(port ? d_ack_o : if_ack_o) && guard < 64) begin
         if (mem_req_o) cyc++;
         guard++;
         @(negedge clk_i);
      end
      if (guard >= 64) begin
         n_cmp++; n_err++;
         $display("FAIL ack_timeout: got no ack expected ack within 64 cycles");
      end
      check("busy_cycles", cyc, exp_busy);
      check("mem_req_in_ack", {31'd0, mem_req_o}, 32'd0);
      // Request stays high across the ack edge; it must not be re-granted.
      @(posedge clk_i);
      #1;
      if_req_i = 1'b0;
      d_req_i  = 1'b0;
      d_we_i   = 1'b0;
      @(negedge clk_i);
      check("no_regrant", {31'd0, busy_o}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      int base;
      int guard;
      rst_i = 1'b1;
      if_req_i = 1'b0; if_addr_i = '0;
      d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0;
      #12;
      check("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
      check("rst_mem_we", {31'd0, mem_we_o}, 32'd0);
      check("rst_mem_addr", mem_addr_o, 32'd0);
      check("rst_acks", {30'd0, if_ack_o, d_ack_o}, 32'd0);
      check("rst_rdata", if_rdata_o | d_rdata_o, 32'd0);
      check("rst_busy_err", {30'd0, busy_o, err_o}, 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;

      txn(1'b0, 1'b0, 32'h40, 32'h0, 3, 32'h00A00093, 3);
      txn(1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 1, 32'h0, 1);
      check("if_rdata_hold", if_rdata_o, 32'h00A00093);
      txn(1'b1, 1'b0, 32'h104, 32'h0, 1, mem_f(32'h104), 1);
      txn(1'b0, 1'b0, 32'h44, 32'h0, 4, mem_f(32'h44), 4);
      check("err_ack_wins", {31'd0, err_o}, 32'd0);

      // Both ports requesting continuously with single-cycle memory.
      mem_lat = 1;
`ifdef MEM_ARB_FAIR_EN
      sb.push_back({1'b1, mem_f(32'h300)});
      sb.push_back({1'b0, mem_f(32'h200)});
      sb.push_back({1'b1, mem_f(32'h300)});
      sb.push_back({1'b0, mem_f(32'h200)});
`else
      for (int i = 0; i < 4; i++) sb.push_back({1'b1, mem_f(32'h300)});
`endif
      base = n_acks;
      @(negedge clk_i);
      if_req_i = 1'b1; if_addr_i = 32'h200;
      d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h300;
      guard = 0;
      while (n_acks < base + 4 && guard < 100) begin
         @(negedge clk_i);
         #1;
         guard++;
      end
      if (guard >= 100) begin
         n_cmp++; n_err++;
         $display("FAIL conflict_timeout: got %0d acks expected 4", n_acks - base);
      end
      if_req_i = 1'b0;
      d_req_i  = 1'b0;
      @(negedge clk_i);
      check("conflict_idle", {31'd0, busy_o}, 32'd0);

      txn(1'b1, 1'b0, 32'h80, 32'h0, 0, 32'h0, 4);
      check("err_set", {31'd0, err_o}, 32'd1);
      repeat (3) @(negedge clk_i);
      check("err_sticky", {31'd0, err_o}, 32'd1);

      // Reset pulsed mid-transaction.
      mem_lat = 0;
      @(negedge clk_i);
      d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h120; d_wdata_i = 32'h12345678;
      @(negedge clk_i);
      check("mid_rst_req_before", {31'd0, mem_req_o}, 32'd1);
      @(negedge clk_i);
      #2;
      rst_i = 1'b1;
      #1;
      check("mid_rst_req_async", {31'd0, mem_req_o}, 32'd0);
      check("mid_rst_busy", {31'd0, busy_o}, 32'd0);
      check("mid_rst_err", {31'd0, err_o}, 32'd0);
      d_req_i = 1'b0;
      d_we_i  = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b0;
      repeat (3) @(negedge clk_i);
      check("post_rst_idle", {31'd0, busy_o}, 32'd0);
      txn(1'b0, 1'b0, 32'h48, 32'h0, 1, mem_f(32'h48), 1);

      repeat (2) @(negedge clk_i);
      check("sb_empty", sb.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Shares one single-port, variable-latency unified memory between the instruction-fetch stage and the MEM stage of the 5-stage RISC-V pipeline. Each stage holds a request until it receives a one-cycle ack; the pipeline's stall logic consumes the acks. The block grants one request at a time and drives the memory handshake. A watchdog aborts a transaction that hangs and flags the error.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT_CYC, 255, maximum busy cycles before abort; legal range 1..1023

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  reset, asynchronous, active-high
- if_req_i  input  1  fetch read request, held until if_ack_o
- if_addr_i  input  ADDR_W  fetch address, stable while if_req_i
- if_rdata_o  output  DATA_W  fetch data, valid with if_ack_o
- if_ack_o  output  1  one-cycle completion pulse for fetch
- d_req_i  input  1  data request, held until d_ack_o
- d_we_i  input  1  1 = write, 0 = read
- d_addr_i  input  ADDR_W  data address
- d_wdata_i  input  DATA_W  write data
- d_rdata_o  output  DATA_W  read data, valid with d_ack_o
- d_ack_o  output  1  one-cycle completion pulse for data
- mem_req_o  output  1  memory request, held until mem_ack_i or abort
- mem_we_o  output  1  memory write enable
- mem_addr_o  output  ADDR_W  memory address
- mem_wdata_o  output  DATA_W  memory write data
- mem_rdata_i  input  DATA_W  memory read data, valid with mem_ack_i
- mem_ack_i  input  1  memory completion, one cycle
- busy_o  output  1  state is not IDLE
- err_o  output  1  sticky timeout flag

## Operation
- States: IDLE, IF_BUSY, D_BUSY.
- IDLE:
  - If any eligible request is pending, pick a winner and register mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o from the winner's inputs.
  - Go to the matching BUSY state.
  - A fetch grant forces mem_we_o = 0.
- Eligibility: a requester whose ack_o is high this cycle is ineligible. Its req is still high at that edge and must not re-grant.
- Priority with only one requester: that requester wins.
- Priority when both request:
  - Default: data wins, because the MEM-stage instruction is older.
- BUSY, on mem_ack_i:
  - Register the winner's ack_o = 1 and rdata_o = mem_rdata_i.
  - Data writes return d_rdata_o = 0.
  - Clear mem_req_o and go to IDLE.
- Watchdog:
  - Counter clears on entry to BUSY and increments each BUSY cycle without mem_ack_i.
  - When the counter reaches TIMEOUT_CYC: abort. Clear mem_req_o, pulse the winner's ack_o with rdata_o = 0, set err_o, go to IDLE.
  - If mem_ack_i and the timeout occur in the same cycle, the ack wins and err_o is not set.
- err_o stays set until reset.
- rdata outputs hold their last value between acks.

## Timing
- Reset values: every output is 0, state = IDLE, counter = 0, last_served = FETCH.
- Reset asserted mid-transaction:
  - The transaction is abandoned immediately and mem_req_o drops asynchronously.
  - No ack is issued.
- Grant latency:
  - req sampled at edge N (IDLE) makes mem_req_o high after edge N.
  - mem_ack_i sampled at edge M makes ack_o high for the cycle after edge M, with mem_req_o low in that same cycle.
- Minimum round trip with single-cycle memory: ack_o 2 cycles after req.
- IDLE bubble: at least one IDLE cycle separates consecutive transactions.
- mem_ack_i is ignored while in IDLE.
- Address and data must be held stable by the requester until its ack.

## Configuration
- MEM_ARB_FAIR_EN undefined:
  - Fixed priority, data always wins a conflict.
  - Fetch may starve while the data port keeps requesting.
- MEM_ARB_FAIR_EN defined:
  - A 1-bit last_served register records the requester that most recently received a grant.
  - On a conflict, the requester that was not last served wins.
  - The first conflict after reset goes to data, since reset sets last_served = FETCH.
  - Single-requester grants also update last_served.

## Structure
- Package mem_arb_pkg:
  - state enum {IDLE, IF_BUSY, D_BUSY}
  - grant constants GNT_FETCH / GNT_DATA
  - watchdog counter width constant WD_W = 10
- Sub-module mem_arb_watchdog:
  - Counter, compare against TIMEOUT_CYC, clear and enable inputs, timeout_o output.
- The FSM, mux and output registers live in the top module.

## Test plan
- if_req_i = 1, if_addr_i = 0x40, memory acks after 3 cycles with 0x00A00093 -> one if_ack_o pulse, if_rdata_o = 0x00A00093, mem_we_o = 0, busy_o back to 0.
- d_req_i = 1, d_we_i = 1, d_addr_i = 0x100, d_wdata_i = 0xDEADBEEF -> mem_we_o = 1, mem_wdata_o = 0xDEADBEEF, d_ack_o pulse, d_rdata_o = 0.
- Both requesting continuously, single-cycle memory:
  - Fair mode off -> data granted every time, no if_ack_o.
  - Fair mode on -> grants alternate D, F, D, F.
- Memory never acks, TIMEOUT_CYC = 4 -> abort after 4 busy cycles, ack_o pulse with rdata 0, err_o = 1 until rst_i.
- mem_ack_i in the same cycle as the timeout -> normal ack with memory data, err_o stays 0.
- rst_i pulsed mid-D_BUSY -> mem_req_o = 0 immediately, no d_ack_o, state IDLE, next request granted normally.
